instr_encoder_loader: RTL and testbench

- Encode side of the control path: takes instruction fields (opcode, registers, immediate) over a valid/ready stream.
- Checks legality and immediate range, packs each legal instruction into a 32-bit word, buffers it in a small FIFO, and writes it to instruction memory at consecutive addresses.
- Used by the program loader and self-test sequencer to populate instruction memory before the core runs.
- Opcode set and encoding match exactly what the core's opcode decoder consumes.

---
 rtl/isa_pkg.sv | 58 +++++
 rtl/instr_fifo.sv | 64 ++++++
 rtl/instr_encoder_loader.sv | 180 ++++++++++++++++++
 tb/tb_instr_encoder_loader.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/isa_pkg.sv
`default_nettype none
// ============================================================================
// Module : isa_pkg
// Brief  : Opcode map, word field positions, instruction formats and loader
//          FSM state codes shared by the encoder/loader and the core decoder.
// Rev    : 1.0  initial release
// ============================================================================
package isa_pkg;

  localparam int OPCODE_W = 4;
  localparam int REG_W    = 4;
  localparam int IMM_W    = 16;
  localparam int INSTR_W  = 32;

  localparam logic [OPCODE_W-1:0] OP_MUL   = 4'b0000;
  localparam logic [OPCODE_W-1:0] OP_DIV   = 4'b0001;
  localparam logic [OPCODE_W-1:0] OP_LOAD  = 4'b0010;
  localparam logic [OPCODE_W-1:0] OP_STORE = 4'b0011;
  localparam logic [OPCODE_W-1:0] OP_ADD   = 4'b0100;
  localparam logic [OPCODE_W-1:0] OP_SUB   = 4'b0101;
  localparam logic [OPCODE_W-1:0] OP_ADDI  = 4'b0110;
  localparam logic [OPCODE_W-1:0] OP_SUBI  = 4'b0111;
  localparam logic [OPCODE_W-1:0] OP_B     = 4'b1000;
  localparam logic [OPCODE_W-1:0] OP_BEQ   = 4'b1001;

  // Bit positions inside the 32-bit instruction word; [15:12] is always zero.
  localparam int POS_OP      = 28;
  localparam int POS_RD      = 24;
  localparam int POS_RN      = 20;
  localparam int POS_RM      = 16;
  localparam int IMM_FIELD_W = 12;
  localparam int IMM8_W      = 8;

  typedef enum logic [1:0] {
    FMT_R   = 2'd0,
    FMT_I8  = 2'd1,
    FMT_M   = 2'd2,
    FMT_ILL = 2'd3
  } fmt_e;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FILL  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  function automatic fmt_e opcode_fmt(input logic [OPCODE_W-1:0] op);
    fmt_e f;
    case (op)
      OP_MUL, OP_DIV, OP_ADD, OP_SUB, OP_BEQ: f = FMT_R;
      OP_ADDI, OP_SUBI, OP_B:                 f = FMT_I8;
      OP_LOAD, OP_STORE:                      f = FMT_M;
      default:                                f = FMT_ILL;
    endcase
    return f;
  endfunction

endpackage
`default_nettype wire

// File: rtl/instr_fifo.sv
`default_nettype none
// ============================================================================
// Module : instr_fifo
// Brief  : Synchronous FIFO for encoded instruction words; head visible on
//          rdata_o one cycle after the push. DEPTH must be a power of two >= 2.
// Rev    : 1.0  initial release
// ============================================================================
module instr_fifo
  import isa_pkg::*;
#(
  parameter int WIDTH = INSTR_W,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
  logic             do_push;
  logic             do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q + (PTR_W+1)'(do_push);
    rd_ptr_d = rd_ptr_q + (PTR_W+1)'(do_pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q[PTR_W-1:0]] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q[PTR_W-1:0]];

endmodule
`default_nettype wire

// File: rtl/instr_encoder_loader.sv
`default_nettype none
// ============================================================================
// Module : instr_encoder_loader
// Brief  : Checks and packs instruction field bundles into 32-bit words,
//          buffers them and writes them to instruction memory sequentially.
// Rev    : 1.0  initial release
// ============================================================================
module instr_encoder_loader
  import isa_pkg::*;
#(
  parameter int ADDR_W     = 10,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [OPCODE_W-1:0] in_opcode,
  input  logic [REG_W-1:0]    in_rd,
  input  logic [REG_W-1:0]    in_rn,
  input  logic [REG_W-1:0]    in_rm,
  input  logic [IMM_W-1:0]    in_imm,
  input  logic                in_last,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [INSTR_W-1:0]  mem_wdata,
  input  logic                mem_ack,
  output logic                busy,
  output logic                done,
  output logic                err_illegal,
  output logic                err_range,
  output logic [ADDR_W-1:0]   word_count
);

  logic [1:0]             state_q, state_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [ADDR_W-1:0]      count_q, count_d;
  logic                   err_ill_q, err_ill_d;
  logic                   err_rng_q, err_rng_d;

  fmt_e                   fmt;
  logic                   imm_ok;
  logic [IMM_FIELD_W-1:0] imm_field;
  logic [REG_W-1:0]       rm_field;
  logic [INSTR_W-1:0]     enc_word;

  logic                   active;
  logic                   accept;
  logic                   push;
  logic                   pop;
  logic                   illegal_hit;
  logic                   range_hit;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [INSTR_W-1:0]     fifo_head;

  // Encoder: format lookup, immediate range check and word packing.
  always_comb begin
    fmt       = opcode_fmt(in_opcode);
    imm_ok    = 1'b1;
    imm_field = '0;
    rm_field  = '0;
    case (fmt)
      FMT_R: begin
        rm_field = in_rm;
      end
      FMT_I8: begin
        imm_ok    = (&in_imm[IMM_W-1:IMM8_W-1]) || !(|in_imm[IMM_W-1:IMM8_W-1]);
        imm_field = {{(IMM_FIELD_W-IMM8_W){1'b0}}, in_imm[IMM8_W-1:0]};
      end
      FMT_M: begin
        imm_ok    = (&in_imm[IMM_W-1:IMM_FIELD_W-1]) ||
                    !(|in_imm[IMM_W-1:IMM_FIELD_W-1]);
        imm_field = in_imm[IMM_FIELD_W-1:0];
      end
      default: begin
        imm_ok = 1'b1;
      end
    endcase

    enc_word                         = '0;
    enc_word[POS_OP +: OPCODE_W]     = in_opcode;
    enc_word[POS_RD +: REG_W]        = in_rd;
    enc_word[POS_RN +: REG_W]        = in_rn;
    enc_word[POS_RM +: REG_W]        = rm_field;
    enc_word[IMM_FIELD_W-1:0]        = imm_field;
  end

  assign active      = (state_q == ST_FILL) || (state_q == ST_DRAIN);
  assign in_ready    = (state_q == ST_FILL) && !fifo_full;
  assign accept      = in_valid && in_ready;
  assign illegal_hit = accept && (fmt == FMT_ILL);
  assign range_hit   = accept && (fmt != FMT_ILL) && !imm_ok;
  assign push        = accept && (fmt != FMT_ILL) && imm_ok;

  assign mem_we      = active && !fifo_empty;
  assign pop         = mem_we && mem_ack;
  // Storage is not reset, so the data bus is forced to zero when idle.
  assign mem_wdata   = mem_we ? fifo_head : '0;
  assign mem_addr    = addr_q;
  assign word_count  = count_q;
  assign busy        = active;
  assign done        = (state_q == ST_DONE);
  assign err_illegal = err_ill_q;
  assign err_range   = err_rng_q;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    count_d   = count_q;
    err_ill_d = err_ill_q;
    err_rng_d = err_rng_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_FILL;
          addr_d    = base_addr;
          count_d   = '0;
          err_ill_d = 1'b0;
          err_rng_d = 1'b0;
        end
      end
      ST_FILL: begin
        if (illegal_hit) err_ill_d = 1'b1;
        if (range_hit)   err_rng_d = 1'b1;
        if (accept && in_last) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (fifo_empty) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Address wraps silently at the top of the memory.
    if (pop) begin
      addr_d  = addr_q + ADDR_W'(1);
      count_d = count_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      count_q   <= '0;
      err_ill_q <= 1'b0;
      err_rng_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      count_q   <= count_d;
      err_ill_q <= err_ill_d;
      err_rng_q <= err_rng_d;
    end
  end

  instr_fifo #(
    .WIDTH (INSTR_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .wdata_i (enc_word),
    .pop_i   (pop),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

endmodule
`default_nettype wire

// File: tb/tb_instr_encoder_loader.sv
`default_nettype none
// ============================================================================
// Module : tb_instr_encoder_loader
// Brief  : Self-checking bench: directed sessions plus random sessions compared
//          against a queue-based reference of the instruction encoding rules.
// Rev    : 1.0  initial release
// ============================================================================
module tb_instr_encoder_loader;

  localparam int ADDR_W = 10;

  logic              clk;
  logic              rst;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        in_opcode;
  logic [3:0]        in_rd;
  logic [3:0]        in_rn;
  logic [3:0]        in_rm;
  logic [15:0]       in_imm;
  logic              in_last;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_ack;
  logic              busy;
  logic              done;
  logic              err_illegal;
  logic              err_range;
  logic [ADDR_W-1:0] word_count;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [31:0]       expq[$];
  logic [ADDR_W-1:0] m_addr;
  logic [ADDR_W-1:0] m_cnt;
  logic              m_ill;
  logic              m_rng;
  int                wr_cyc[$];
  logic [31:0]       last_wdata;
  logic [ADDR_W-1:0] last_addr;
  int                cyc = 0;
  bit                ack_on = 0;
  bit                ack_rand = 0;
  int                bnd[8] = '{-129, -128, 127, 128, -2049, -2048, 2047, 2048};

  instr_encoder_loader #(
    .ADDR_W     (ADDR_W),
    .FIFO_DEPTH (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .base_addr   (base_addr),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_opcode   (in_opcode),
    .in_rd       (in_rd),
    .in_rn       (in_rn),
    .in_rm       (in_rm),
    .in_imm      (in_imm),
    .in_last     (in_last),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_ack     (mem_ack),
    .busy        (busy),
    .done        (done),
    .err_illegal (err_illegal),
    .err_range   (err_range),
    .word_count  (word_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Memory side: ack is updated just after each rising edge.
  initial begin
    mem_ack = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      mem_ack = ack_on && (!ack_rand || ($urandom % 3 != 0));
    end
  end

  // Write monitor: every accepted write is matched against the expected queue.
  initial begin
    logic              hold_pend;
    logic [ADDR_W-1:0] hold_addr;
    logic [31:0]       hold_data;
    logic [31:0]       exp_w;
    hold_pend = 1'b0;
    hold_addr = '0;
    hold_data = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (mem_we && hold_pend) begin
        check("hold_addr", 32'(mem_addr), 32'(hold_addr));
        check("hold_data", mem_wdata, hold_data);
      end
      if (mem_we && mem_ack) begin
        check("write_expected", (expq.size() != 0) ? 32'd1 : 32'd0, 32'd1);
        if (expq.size() != 0) begin
          exp_w = expq.pop_front();
          check("write_data", mem_wdata, exp_w);
          check("write_addr", 32'(mem_addr), 32'(m_addr));
          last_wdata = mem_wdata;
          last_addr  = mem_addr;
          wr_cyc.push_back(cyc);
          m_addr = m_addr + 1'b1;
          m_cnt  = m_cnt + 1'b1;
        end
      end
      hold_pend = mem_we && !mem_ack;
      hold_addr = mem_addr;
      hold_data = mem_wdata;
    end
  end

  // Reference encoding straight from the format rules.
  task automatic model_accept();
    int          op;
    int          si;
    int          kind;
    logic [31:0] d;
    op = int'(in_opcode);
    si = $signed(in_imm);
    case (op)
      0, 1, 4, 5, 9: kind = 0;
      6, 7, 8:       kind = 1;
      2, 3:          kind = 2;
      default:       kind = 3;
    endcase
    if (kind == 3) begin
      m_ill = 1'b1;
    end else if ((kind == 1 && (si < -128 || si > 127)) ||
                 (kind == 2 && (si < -2048 || si > 2047))) begin
      m_rng = 1'b1;
    end else begin
      d = 32'(op) * 32'h1000_0000 + 32'(in_rd) * 32'h0100_0000 + 32'(in_rn) * 32'h0010_0000;
      if (kind == 0)      d = d + 32'(in_rm) * 32'h0001_0000;
      else if (kind == 1) d = d + 32'(si % 256 + 256) % 256;
      else                d = d + 32'(si % 4096 + 4096) % 4096;
      expq.push_back(d);
    end
  endtask

  task automatic present(input int op, input int rd, input int rn, input int rm,
                         input int imm, input bit last);
    in_valid  = 1'b1;
    in_opcode = op[3:0];
    in_rd     = rd[3:0];
    in_rn     = rn[3:0];
    in_rm     = rm[3:0];
    in_imm    = imm[15:0];
    in_last   = last;
  endtask

  task automatic wait_accept();
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("accept_within_bound", 32'(in_ready), 32'd1);
    if (in_ready) model_accept();
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send(input int op, input int rd, input int rn, input int rm,
                      input int imm, input bit last);
    present(op, rd, rn, rm, imm, last);
    wait_accept();
  endtask

  task automatic start_session(input logic [ADDR_W-1:0] b, input string tag);
    @(posedge clk);
    #1;
    start     = 1'b1;
    base_addr = b;
    @(posedge clk);
    #1;
    start  = 1'b0;
    m_addr = b;
    m_cnt  = '0;
    m_ill  = 1'b0;
    m_rng  = 1'b0;
    expq.delete();
    @(negedge clk);
    check({tag, "_busy_after_start"}, 32'(busy), 32'd1);
    check({tag, "_count_after_start"}, 32'(word_count), 32'd0);
    check({tag, "_addr_after_start"}, 32'(mem_addr), 32'(b));
    check({tag, "_errs_after_start"}, {30'd0, err_illegal, err_range}, 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic end_session(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (!done && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    check({tag, "_word_count"}, 32'(word_count), 32'(m_cnt));
    check({tag, "_err_illegal"}, 32'(err_illegal), 32'(m_ill));
    check({tag, "_err_range"}, 32'(err_range), 32'(m_rng));
    check({tag, "_all_written"}, 32'(expq.size()), 32'd0);
    @(negedge clk);
    check({tag, "_done_one_cycle"}, 32'(done), 32'd0);
  endtask

  task automatic random_session(input string tag);
    int imm;
    start_session(10'($urandom), tag);
    for (int i = 0; i < 40; i++) begin
      case ($urandom % 4)
        0:       imm = int'($urandom % 65536) - 32768;
        1:       imm = int'($urandom % 261) - 130;
        2:       imm = int'($urandom % 4101) - 2050;
        default: imm = bnd[$urandom % 8];
      endcase
      repeat ($urandom % 2) begin
        @(posedge clk);
        #1;
      end
      send(int'($urandom % 16), int'($urandom % 16), int'($urandom % 16),
           int'($urandom % 16), imm, i == 39);
    end
    end_session(tag);
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    base_addr = '0;
    in_valid  = 1'b0;
    in_opcode = '0;
    in_rd     = '0;
    in_rn     = '0;
    in_rm     = '0;
    in_imm    = '0;
    in_last   = 1'b0;
    m_addr    = '0;
    m_cnt     = '0;
    m_ill     = 1'b0;
    m_rng     = 1'b0;
    last_wdata = '0;
    last_addr  = '0;

    #12;
    check("rst_outputs", {25'd0, mem_we, in_ready, busy, done, err_illegal, err_range, 1'b0}, 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_word_count", 32'(word_count), 32'd0);
    #5;
    rst    = 1'b0;
    ack_on = 1'b1;

    // 1: single addi with negative immediate
    start_session(10'h010, "t1");
    send(6, 1, 2, 0, -5, 1);
    end_session("t1");
    check("t1_data", last_wdata, 32'h612000FB);
    check("t1_addr", 32'(last_addr), 32'h010);

    // 2: back-to-back writes with ack held high
    start_session(10'h000, "t2");
    wr_cyc.delete();
    send(2, 3, 4, 0, 100, 0);
    send(3, 1, 2, 0, -2048, 0);
    send(0, 5, 6, 7, 0, 1);
    end_session("t2");
    check("t2_nwrites", 32'(wr_cyc.size()), 32'd3);
    if (wr_cyc.size() == 3) check("t2_consecutive", 32'(wr_cyc[2] - wr_cyc[0]), 32'd2);
    check("t2_last_data", last_wdata, 32'h05670000);
    check("t2_last_addr", 32'(last_addr), 32'h002);

    // 3: range error, illegal opcode, one legal word
    start_session(10'h020, "t3");
    send(6, 1, 2, 0, 200, 0);
    send(12, 1, 2, 3, 0, 0);
    send(4, 1, 1, 1, 0, 1);
    end_session("t3");
    check("t3_data", last_wdata, 32'h41110000);
    check("t3_flags_held", {30'd0, err_illegal, err_range}, 32'd3);

    // 3b: session with no legal word still completes
    start_session(10'h030, "t3b");
    send(15, 0, 0, 0, 0, 1);
    end_session("t3b");

    // 4: memory stalls, FIFO fills, data held stable
    ack_on = 1'b0;
    start_session(10'h040, "t4");
    for (int i = 0; i < 4; i++) send(4, i, i + 1, i + 2, 0, 0);
    present(5, 4, 5, 6, 0, 0);
    repeat (20) begin
      @(negedge clk);
      check("t4_in_ready_full", 32'(in_ready), 32'd0);
    end
    check("t4_we_stalled", 32'(mem_we), 32'd1);
    check("t4_addr_stalled", 32'(mem_addr), 32'h040);
    check("t4_no_writes", 32'(word_count), 32'd0);
    ack_on = 1'b1;
    wait_accept();
    send(3, 6, 7, 0, 2047, 0);
    send(8, 0, 0, 0, -128, 0);
    send(1, 8, 9, 10, 0, 1);
    end_session("t4");

    // 5: address wrap at top of memory
    start_session(10'h3FF, "t5");
    send(4, 1, 2, 3, 0, 0);
    send(7, 4, 5, 6, 127, 1);
    end_session("t5");
    check("t5_wrap_addr", 32'(last_addr), 32'h000);

    // 6: asynchronous reset mid-session
    ack_on = 1'b0;
    start_session(10'h080, "t6");
    send(4, 1, 2, 3, 0, 0);
    send(5, 1, 2, 3, 0, 0);
    @(negedge clk);
    check("t6_we_before_rst", 32'(mem_we), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("t6_rst_async", {29'd0, mem_we, busy, in_ready}, 32'd0);
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b0;
    ack_on = 1'b1;
    start_session(10'h0A0, "t6r");
    send(5, 2, 3, 4, 0, 1);
    end_session("t6r");

    // 7: random sessions with random acks
    ack_rand = 1'b1;
    random_session("r1");
    random_session("r2");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
